// File: rtl/nn_ctrl_pkg.sv
// Shared types and defaults for the network fetch/compute controller.
// Holds the sequencer state enum, layer constants and the default fetch timeout.
package nn_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        IMG_REQ,
        IMG_WAIT,
        COEF_REQ,
        COEF_WAIT,
        COMPUTE,
        COMP_WAIT,
        FINISH,
        FAULT
    } state_t;

    localparam int unsigned IMG_LAYERS         = 3;
    localparam int unsigned DEF_LAST_LAYER     = 2;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 4096;

endpackage

// File: rtl/fetch_timer.sv
// Fetch watchdog counter.
//   clk, reset_n : clock, async active-low reset
//   clear        : restart the count at zero (asserted on the cycle before a wait state)
//   enable       : count one cycle (asserted while waiting on memory)
//   expired      : count has reached TIMEOUT_CYCLES-1 (decoded from the count register)
module fetch_timer
    import nn_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned TBITS          = 13
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TBITS-1:0] count_q;
    logic [TBITS-1:0] count_d;

    assign expired = (count_q == TBITS'(TIMEOUT_CYCLES - 1));

    // Saturate at the expiry value so the flag stays up until cleared.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + TBITS'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/layer_fetch_sequencer.sv
// Sequences one inference: fetch image, then per layer fetch coefficients and
// run the compute layer, finally pulse done. A fetch that stalls trips a
// sticky error that only a new start clears.
//   clk, reset_n          : clock, async active-low reset
//   start                 : begin an inference (pulse)
//   get_image, get_coeffs : memory fetch requests (one-cycle pulses); layer = coeff layer
//   mem_busy              : memory interface busy
//   layer_start/layer_idx : compute layer go (pulse) and the layer being computed
//   compute_done          : compute layer finished (pulse)
//   done, error, seq_busy : inference complete (pulse), timeout (sticky), not idle
module layer_fetch_sequencer
    import nn_ctrl_pkg::*;
#(
    parameter int unsigned NUMLAYERS      = 2,
    parameter int unsigned LAST_LAYER     = DEF_LAST_LAYER,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned TBITS          = 13
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    output logic                 get_image,
    output logic                 get_coeffs,
    output logic [NUMLAYERS-1:0] layer,
    input  logic                 mem_busy,
    output logic                 layer_start,
    output logic [NUMLAYERS-1:0] layer_idx,
    input  logic                 compute_done,
    output logic                 done,
    output logic                 error,
    output logic                 seq_busy
);

    localparam logic [NUMLAYERS-1:0] LAST_IDX = NUMLAYERS'(LAST_LAYER);

    state_t               state_q, state_d;
    logic [NUMLAYERS-1:0] cur_layer_q, cur_layer_d;
    logic [NUMLAYERS-1:0] layer_q, layer_d;
    logic [NUMLAYERS-1:0] layer_idx_q, layer_idx_d;
    logic                 start_pending_q, start_pending_d;
    logic                 seen_busy_q, seen_busy_d;
    logic                 get_image_q, get_image_d;
    logic                 get_coeffs_q, get_coeffs_d;
    logic                 layer_start_q, layer_start_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
    logic                 seq_busy_q, seq_busy_d;

    logic tmr_clear;
    logic tmr_enable;
    logic tmr_expired;

    // Timer restarts while in a request state so it reads zero on wait entry.
    assign tmr_clear  = (state_q == IMG_REQ) || (state_q == COEF_REQ);
    assign tmr_enable = (state_q == IMG_WAIT) || (state_q == COEF_WAIT);

    fetch_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TBITS         (TBITS)
    ) u_fetch_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (tmr_clear),
        .enable (tmr_enable),
        .expired(tmr_expired)
    );

    // Next state and next registered outputs.
    always_comb begin
        state_d         = state_q;
        cur_layer_d     = cur_layer_q;
        start_pending_d = start_pending_q;
        seen_busy_d     = seen_busy_q;
        error_d         = error_q;

        case (state_q)
            IDLE: begin
                if (start_pending_q && !mem_busy) begin
                    state_d         = IMG_REQ;
                    start_pending_d = 1'b0;
                end else if (start) begin
                    start_pending_d = 1'b1;
                end
            end
            IMG_REQ: begin
                state_d     = IMG_WAIT;
                seen_busy_d = 1'b0;
            end
            IMG_WAIT: begin
                seen_busy_d = seen_busy_q | mem_busy;
                if (seen_busy_q && !mem_busy) begin
                    state_d     = COEF_REQ;
                    cur_layer_d = '0;
                end else if (tmr_expired) begin
                    state_d = FAULT;
                end
            end
            COEF_REQ: begin
                state_d     = COEF_WAIT;
                seen_busy_d = 1'b0;
            end
            COEF_WAIT: begin
                seen_busy_d = seen_busy_q | mem_busy;
                if (seen_busy_q && !mem_busy) begin
                    state_d = COMPUTE;
                end else if (tmr_expired) begin
                    state_d = FAULT;
                end
            end
            COMPUTE: begin
                state_d = COMP_WAIT;
            end
            COMP_WAIT: begin
                if (compute_done) begin
                    if (cur_layer_q == LAST_IDX) begin
                        state_d = FINISH;
                    end else begin
                        state_d     = COEF_REQ;
                        cur_layer_d = cur_layer_q + NUMLAYERS'(1);
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            FAULT: begin
                // Start only acknowledges the fault; a fetch needs a further start.
                if (start) begin
                    state_d = IDLE;
                    error_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == FAULT) begin
            error_d = 1'b1;
        end

        get_image_d   = (state_d == IMG_REQ);
        get_coeffs_d  = (state_d == COEF_REQ);
        layer_start_d = (state_d == COMPUTE);
        done_d        = (state_d == FINISH);
        seq_busy_d    = (state_d != IDLE);
        layer_d       = (state_d == COEF_REQ) ? cur_layer_d : layer_q;
        layer_idx_d   = (state_d == COMPUTE) ? cur_layer_d : layer_idx_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            cur_layer_q     <= '0;
            layer_q         <= '0;
            layer_idx_q     <= '0;
            start_pending_q <= 1'b0;
            seen_busy_q     <= 1'b0;
            get_image_q     <= 1'b0;
            get_coeffs_q    <= 1'b0;
            layer_start_q   <= 1'b0;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
            seq_busy_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            cur_layer_q     <= cur_layer_d;
            layer_q         <= layer_d;
            layer_idx_q     <= layer_idx_d;
            start_pending_q <= start_pending_d;
            seen_busy_q     <= seen_busy_d;
            get_image_q     <= get_image_d;
            get_coeffs_q    <= get_coeffs_d;
            layer_start_q   <= layer_start_d;
            done_q          <= done_d;
            error_q         <= error_d;
            seq_busy_q      <= seq_busy_d;
        end
    end

    assign get_image   = get_image_q;
    assign get_coeffs  = get_coeffs_q;
    assign layer       = layer_q;
    assign layer_start = layer_start_q;
    assign layer_idx   = layer_idx_q;
    assign done        = done_q;
    assign error       = error_q;
    assign seq_busy    = seq_busy_q;

endmodule

// File: tb/tb_layer_fetch_sequencer.sv
// Self-checking bench for layer_fetch_sequencer. A memory model and a compute
// model react to the sequencer's requests; from the inputs they drive, the
// bench predicts which pulse must appear and on which cycle.
module tb_layer_fetch_sequencer;

    localparam int NL   = 2;
    localparam int LAST = 2;
    localparam int TO   = 4096;

    localparam int K_NONE  = 0;
    localparam int K_IMG   = 1;
    localparam int K_COEF  = 2;
    localparam int K_LS    = 3;
    localparam int K_DONE  = 4;
    localparam int K_MULTI = 7;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic          mem_busy;
    logic          compute_done;
    logic          get_image;
    logic          get_coeffs;
    logic          layer_start;
    logic          done;
    logic          error;
    logic          seq_busy;
    logic [NL-1:0] layer;
    logic [NL-1:0] layer_idx;

    layer_fetch_sequencer #(
        .NUMLAYERS     (NL),
        .LAST_LAYER    (LAST),
        .TIMEOUT_CYCLES(TO),
        .TBITS         (13)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .get_image   (get_image),
        .get_coeffs  (get_coeffs),
        .layer       (layer),
        .mem_busy    (mem_busy),
        .layer_start (layer_start),
        .layer_idx   (layer_idx),
        .compute_done(compute_done),
        .done        (done),
        .error       (error),
        .seq_busy    (seq_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;
    int cyc;

    // Reference model state
    int exp_tick, exp_kind, exp_layer;
    int m_layer;
    int busy_left, busy_kind, arm_kind;
    bit busy_arm;
    int blen [4];
    int cd_left, cd_len;
    bit ignore_l1, spur_cd, spur_st;
    int n_img, n_coef, n_ls, n_done;
    int req_tick;

    task automatic model_reset();
        exp_tick  = -1; exp_kind = K_NONE; exp_layer = 0;
        m_layer   = 0;
        busy_left = 0; busy_kind = 0; arm_kind = 0; busy_arm = 1'b0;
        cd_left   = 0;
        ignore_l1 = 1'b0; spur_cd = 1'b0; spur_st = 1'b0;
        n_img = 0; n_coef = 0; n_ls = 0; n_done = 0;
        start = 1'b0; mem_busy = 1'b0; compute_done = 1'b0;
    endtask

    // Advance one cycle: check pulses, then let the models respond.
    task automatic tick();
        int obs, cnt, want;
        @(posedge clk);
        #1;
        cyc++;
        start        = 1'b0;
        compute_done = 1'b0;
        cnt = int'(get_image) + int'(get_coeffs) + int'(layer_start) + int'(done);
        if (cnt > 1)          obs = K_MULTI;
        else if (get_image)   obs = K_IMG;
        else if (get_coeffs)  obs = K_COEF;
        else if (layer_start) obs = K_LS;
        else if (done)        obs = K_DONE;
        else                  obs = K_NONE;
        want = (exp_tick == cyc) ? exp_kind : K_NONE;
        if (obs != K_NONE || want != K_NONE) begin
            n_cmp++;
            if (obs != want) begin
                n_bad++;
                $display("FAIL pulse cyc=%0d: got kind %0d, expected kind %0d", cyc, obs, want);
            end else if ((obs == K_COEF && int'(layer) != exp_layer) ||
                         (obs == K_LS && int'(layer_idx) != exp_layer)) begin
                n_bad++;
                $display("FAIL layer cyc=%0d: got layer=%0d idx=%0d, expected %0d",
                         cyc, layer, layer_idx, exp_layer);
            end
        end
        if (get_image)   n_img++;
        if (get_coeffs)  begin n_coef++; req_tick = cyc; end
        if (layer_start) n_ls++;
        if (done)        n_done++;

        // Compute model
        if (cd_left > 0) begin
            cd_left--;
            if (cd_left == 0) begin
                compute_done = 1'b1;
                exp_tick     = cyc + 1;
                if (m_layer == LAST) begin
                    exp_kind = K_DONE;
                end else begin
                    m_layer++;
                    exp_kind  = K_COEF;
                    exp_layer = m_layer;
                end
            end else if (spur_st && cd_left == cd_len / 2) begin
                start = 1'b1;
            end
        end
        if (layer_start) cd_left = cd_len;

        // Memory model
        if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
                mem_busy = 1'b0;
                exp_tick = cyc + 1;
                case (busy_kind)
                    0: exp_kind = K_IMG;
                    1: begin exp_kind = K_COEF; exp_layer = 0; m_layer = 0; end
                    default: begin exp_kind = K_LS; exp_layer = m_layer; end
                endcase
            end else if (spur_cd && busy_kind == 2 && busy_left == 2) begin
                compute_done = 1'b1;
            end
        end
        if (busy_arm) begin
            busy_arm  = 1'b0;
            mem_busy  = 1'b1;
            busy_kind = arm_kind;
            busy_left = (arm_kind == 1) ? blen[0] : blen[m_layer + 1];
        end
        if (get_image) begin
            busy_arm = 1'b1; arm_kind = 1;
        end else if (get_coeffs && !(ignore_l1 && m_layer == 1)) begin
            busy_arm = 1'b1; arm_kind = 2;
        end
    endtask

    task automatic run_inference(input int li, input int l0, input int l1, input int l2,
                                 input int cd, input bit busy_first, input string name);
        int budget;
        blen[0] = li; blen[1] = l0; blen[2] = l1; blen[3] = l2;
        cd_len  = cd;
        n_img = 0; n_coef = 0; n_ls = 0; n_done = 0;
        if (busy_first) begin
            mem_busy  = 1'b1;
            busy_left = 5;
            busy_kind = 0;
            start     = 1'b1;
        end else begin
            start    = 1'b1;
            exp_tick = cyc + 2;
            exp_kind = K_IMG;
        end
        budget = 0;
        while (n_done == 0 && budget < 8000) begin
            tick();
            budget++;
        end
        n_cmp++;
        if (n_done == 0) begin
            n_bad++;
            $display("FAIL %s done timeout: got no done, expected done within 8000 cycles", name);
        end
        n_cmp++;
        if (n_img != 1 || n_coef != 3 || n_ls != 3 || error !== 1'b0) begin
            n_bad++;
            $display("FAIL %s counts: got img=%0d coef=%0d ls=%0d err=%b, expected 1/3/3/0",
                     name, n_img, n_coef, n_ls, error);
        end
        n_cmp++;
        if (int'(layer) != LAST || int'(layer_idx) != LAST) begin
            n_bad++;
            $display("FAIL %s hold: got layer=%0d idx=%0d, expected %0d", name, layer, layer_idx, LAST);
        end
        tick();
        n_cmp++;
        if (seq_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s idle: got seq_busy=%b, expected 0", name, seq_busy);
        end
        repeat (8) tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (3) tick();
        n_cmp++;
        if ({get_image, get_coeffs, layer_start, done, error, seq_busy, layer, layer_idx} !== '0) begin
            n_bad++;
            $display("FAIL reset outputs: got %b, expected all zero",
                     {get_image, get_coeffs, layer_start, done, error, seq_busy, layer, layer_idx});
        end
        reset_n = 1'b1;
        repeat (6) tick();
        n_cmp++;
        if (seq_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset release: got seq_busy=%b, expected 0", seq_busy);
        end
    endtask

    task automatic test_nominal();
        model_reset();
        run_inference(64, 2048, 128, 80, 10, 1'b0, "nominal");
    endtask

    task automatic test_random();
        for (int i = 0; i < 5; i++) begin
            model_reset();
            run_inference(int'($urandom_range(1, 40)), int'($urandom_range(1, 40)),
                          int'($urandom_range(1, 40)), int'($urandom_range(1, 40)),
                          int'($urandom_range(1, 15)), 1'b0, "random");
        end
    endtask

    task automatic test_busy_at_start();
        model_reset();
        run_inference(12, 9, 7, 5, 4, 1'b1, "busy_start");
    endtask

    task automatic test_spurious();
        model_reset();
        spur_cd = 1'b1;
        spur_st = 1'b1;
        run_inference(8, 8, 8, 8, 10, 1'b0, "spurious");
        model_reset();
    endtask

    task automatic test_timeout();
        int budget, err_tick;
        model_reset();
        ignore_l1 = 1'b1;
        blen[0] = 6; blen[1] = 6; blen[2] = 6; blen[3] = 6;
        cd_len  = 3;
        start    = 1'b1;
        exp_tick = cyc + 2;
        exp_kind = K_IMG;
        err_tick = -1;
        budget   = 0;
        while (budget < 5000) begin
            tick();
            budget++;
            if (error === 1'b1) begin
                err_tick = cyc;
                break;
            end
        end
        n_cmp++;
        if (err_tick != req_tick + TO + 1 || n_coef != 2) begin
            n_bad++;
            $display("FAIL timeout cycle: got error at %0d (coef reqs %0d), expected %0d (2)",
                     err_tick, n_coef, req_tick + TO + 1);
        end
        n_cmp++;
        if (get_coeffs !== 1'b0 || get_image !== 1'b0 || seq_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL fault outputs: got gi=%b gc=%b busy=%b, expected 0/0/1",
                     get_image, get_coeffs, seq_busy);
        end
        start = 1'b1;
        tick();
        n_cmp++;
        if (error !== 1'b0 || seq_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL fault clear: got error=%b seq_busy=%b, expected 0/0", error, seq_busy);
        end
        repeat (10) tick();
        model_reset();
    endtask

    task automatic test_reset_mid();
        int budget;
        model_reset();
        blen[0] = 20; blen[1] = 20; blen[2] = 20; blen[3] = 20;
        cd_len  = 5;
        start    = 1'b1;
        exp_tick = cyc + 2;
        exp_kind = K_IMG;
        budget   = 0;
        while (!(busy_kind == 2 && m_layer == 1 && busy_left == 10) && budget < 500) begin
            tick();
            budget++;
        end
        n_cmp++;
        if (budget >= 500) begin
            n_bad++;
            $display("FAIL reset_mid reach: got no layer 1 fetch, expected one within 500 cycles");
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({get_image, get_coeffs, layer_start, done, error, seq_busy, layer, layer_idx} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid outputs: got %b, expected all zero",
                     {get_image, get_coeffs, layer_start, done, error, seq_busy, layer, layer_idx});
        end
        model_reset();
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (20) tick();
        n_cmp++;
        if (seq_busy !== 1'b0 || error !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid idle: got seq_busy=%b error=%b, expected 0/0", seq_busy, error);
        end
        run_inference(5, 5, 5, 5, 3, 1'b0, "after_reset");
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        cyc      = 0;
        req_tick = 0;
        cd_len   = 1;
        for (int i = 0; i < 4; i++) blen[i] = 1;
        test_reset();
        test_nominal();
        test_random();
        test_busy_at_start();
        test_spurious();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
